// File: rtl/i2s_slave_rx.sv
// i2s_slave_rx: I2S receiver (bus slave) that recovers stereo PCM samples.
//   BCK, LCK and DIN are asynchronous to CLK. Each input passes through a
//   2-FF synchroniser. A rising edge of the synchronised BCK is a bit event.
//   On each bit event DIN is shifted in MSB-first. Words are left-justified,
//   and anything past WIDTH bits is truncated.
//   A left word is held until its right partner completes. L and R are then
//   updated together, with a one-cycle VALID strobe.
// Ports:
//   CLK   - system clock
//   RST   - synchronous active-high reset
//   BCK   - I2S bit clock (async, <= CLK/4)
//   LCK   - I2S word select (async; 0 = left, 1 = right)
//   DIN   - I2S serial data (async; changes on BCK falling edge)
//   L, R  - last complete left / right sample (WIDTH bits, two's complement)
//   VALID - one-CLK strobe when L/R hold a fresh pair
module i2s_slave_rx #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             BCK,
  input  logic             LCK,
  input  logic             DIN,
  output logic [WIDTH-1:0] L,
  output logic [WIDTH-1:0] R,
  output logic             VALID
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] WIDTH_C = CW'(WIDTH);

  // Synchroniser chains. Bit 0 is the first stage.
  // bck_sync_q[2] is the edge-detect history register.
  logic [2:0]       bck_sync_q, bck_sync_d;
  logic [1:0]       lck_sync_q, lck_sync_d;
  logic [1:0]       din_sync_q, din_sync_d;

  logic             started_q, started_d;
  logic             lck_last_q, lck_last_d;
  logic [1:0]       armed_q, armed_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic [WIDTH-1:0] hold_l_q, hold_l_d;
  logic             have_l_q, have_l_d;
  logic [WIDTH-1:0] l_q, l_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             valid_q, valid_d;

  logic             bit_event;
  logic             lck_s;
  logic             din_s;
  logic [WIDTH-1:0] din_bit;
  logic [WIDTH-1:0] word_fin;

  always_comb begin
    bck_sync_d = {bck_sync_q[1:0], BCK};
    lck_sync_d = {lck_sync_q[0], LCK};
    din_sync_d = {din_sync_q[0], DIN};

    bit_event  = bck_sync_q[1] & ~bck_sync_q[2];
    lck_s      = lck_sync_q[1];
    din_s      = din_sync_q[1];

    // The shift word is cleared at each slot start.
    // Each bit position is written at most once, so OR-ing in a mask is enough.
    din_bit    = '0;
    if (count_q < WIDTH_C) begin
      din_bit = WIDTH'(din_s) << (WIDTH_C - CW'(1) - count_q);
    end
    word_fin   = word_q | din_bit;

    started_d  = started_q;
    lck_last_d = lck_last_q;
    armed_d    = armed_q;
    count_d    = count_q;
    word_d     = word_q;
    hold_l_d   = hold_l_q;
    have_l_d   = have_l_q;
    l_d        = l_q;
    r_d        = r_q;
    valid_d    = 1'b0;

    if (bit_event) begin
      if (!started_q) begin
        // The first observed slot is partial: only learn its channel, leave it disarmed.
        started_d  = 1'b1;
        lck_last_d = lck_s;
      end else if (lck_s != lck_last_q) begin
        // I2S one-bit delay: this DIN is the last bit of the ending slot.
        if (!lck_last_q) begin
          if (armed_q[0]) begin
            hold_l_d = word_fin;
            have_l_d = 1'b1;
          end
        end else if (armed_q[1] && have_l_q) begin
          r_d      = word_fin;
          l_d      = hold_l_q;
          valid_d  = 1'b1;
          have_l_d = 1'b0;
        end
        word_d         = '0;
        count_d        = '0;
        armed_d[lck_s] = 1'b1;
        lck_last_d     = lck_s;
      end else if (count_q < WIDTH_C) begin
        word_d  = word_fin;
        count_d = count_q + CW'(1);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      bck_sync_q <= '0;
      lck_sync_q <= '0;
      din_sync_q <= '0;
      started_q  <= 1'b0;
      lck_last_q <= 1'b0;
      armed_q    <= '0;
      count_q    <= '0;
      word_q     <= '0;
      hold_l_q   <= '0;
      have_l_q   <= 1'b0;
      l_q        <= '0;
      r_q        <= '0;
      valid_q    <= 1'b0;
    end else begin
      bck_sync_q <= bck_sync_d;
      lck_sync_q <= lck_sync_d;
      din_sync_q <= din_sync_d;
      started_q  <= started_d;
      lck_last_q <= lck_last_d;
      armed_q    <= armed_d;
      count_q    <= count_d;
      word_q     <= word_d;
      hold_l_q   <= hold_l_d;
      have_l_q   <= have_l_d;
      l_q        <= l_d;
      r_q        <= r_d;
      valid_q    <= valid_d;
    end
  end

  assign L     = l_q;
  assign R     = r_q;
  assign VALID = valid_q;

endmodule

// File: doc/i2s_slave_rx.md
Name: i2s_slave_rx

Overview:
- I2S receiver (bus slave): recovers stereo PCM samples from an external BCK/LCK/DIN stream, e.g. an I2S ADC or a codebase I2S master looped back.
- All three inputs are asynchronous to CLK. They are synchronised, BCK rising edges are detected, and DIN is shifted in MSB-first.
- Outputs a left/right pair with a one-cycle VALID strobe per stereo frame, in the CLK domain.
- Sits between an external audio source and the sample-processing logic.

Parameters:
WIDTH, 16, output sample width in bits (two's complement); also the maximum number of bits captured per slot.

Ports:
CLK  input  1  system clock, 12 MHz nominal; reset is synchronous and active-high
RST  input  1  synchronous active-high reset
BCK  input  1  I2S bit clock, async to CLK; frequency <= CLK/4
LCK  input  1  I2S word select, async; 0 = left slot, 1 = right slot
DIN  input  1  I2S serial data, async; changes on BCK falling edge
L    output WIDTH  last complete left sample
R    output WIDTH  last complete right sample
VALID output 1  one-CLK strobe: L/R hold a fresh, consistent pair

Behaviour:
- Synchronisation:
  - BCK, LCK and DIN each pass through an identical 2-FF synchroniser.
  - BCK gets a third register for edge detection.
  - bit_event = sync BCK is 1 and previous BCK is 0.
  - LCK and DIN are sampled only on bit_event, so all three see equal delay.
- Latency: registered effects of a bit_event take effect on the 3rd CLK rising edge at which raw BCK is high (2 sync stages + 1 register).
- On each bit_event, lck_s (synchronised LCK) is compared with lck_last (LCK sampled on the previous bit_event).
- Slot boundary (lck_s != lck_last):
  - The current DIN bit belongs to the ending slot (I2S one-bit delay). If count < WIDTH it is written at bit position WIDTH-1-count; otherwise it is dropped.
  - Commit: the ending slot's word goes to hold_L when lck_last==0, or to R when lck_last==1. This happens only if that slot is armed.
  - Start of the new slot: clear the shift word to 0, set count=0, arm the new slot (armed flag per channel = lck_s), update lck_last.
- Within a slot (lck_s == lck_last):
  - If count < WIDTH: write DIN at bit WIDTH-1-count and increment count.
  - If count >= WIDTH: ignore DIN (truncation); count saturates at WIDTH.
- Short slots (fewer than WIDTH bits) are zero-padded at the LSB end, i.e. left-justified.
- Left holding: a left commit writes hold_L and sets have_L=1. L itself is not updated.
- Right commit:
  - If have_L=1: on that same cycle R <= word, L <= hold_L, VALID=1, have_L <= 0.
  - If have_L=0 (right slot without a preceding armed left): R and L are unchanged and VALID stays 0.
- VALID is high exactly one CLK per frame and never on consecutive cycles. L/R are stable between strobes.
- Startup and mid-slot entry:
  - After reset both slots are disarmed and lck_last is taken from the first bit_event.
  - A partially observed slot is never committed. The first VALID follows the first fully observed left slot followed by a fully observed right slot.
- Reset (synchronous, RST=1 at a CLK edge):
  - L=0, R=0, VALID=0, hold_L=0, have_L=0, count=0, shift word=0, armed flags=0.
  - Synchroniser and edge registers are cleared to 0.
  - Reset overrides a simultaneous bit_event. Reset mid-frame discards all partial data.
- LCK changing with no BCK activity has no effect until the next bit_event.

Test Plan:
- RST held 4 CLK, then released with BCK idle -> L=0x0000, R=0x0000, VALID=0 indefinitely.
- CLK 12 MHz, BCK 3 MHz, 32-BCK slots, L=0x1234, R=0xABCD (MSB one BCK after each LCK edge) -> after the 2nd full frame exactly one VALID pulse per frame, coincident with the R-to-L boundary; L=0x1234, R=0xABCD; VALID pulse count equals frame count minus 1.
- 16-BCK slots (LSB arrives on the LCK-change edge), L=0x8001, R=0x7FFE -> L=0x8001, R=0x7FFE.
- 24-bit words 0x89ABCD/0x123456 in 32-BCK slots, WIDTH=16 -> L=0x89AB, R=0x1234; 8-bit words 0xA5/0x5A in 8-BCK slots -> L=0xA500, R=0x5A00.
- Stream starts mid-left slot -> no VALID for the partial frame; first VALID after the next full left+right pair carries that pair's values.
- RST pulsed for 1 CLK mid right slot of frame (L=0x1111, R=0x2222) -> L=R=0 and VALID=0 immediately; that frame is not reported; the next full frame (0x3333/0x4444) -> VALID with L=0x3333, R=0x4444.
